// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 15;
  localparam int unsigned DEF_DATA_W = 16;

  // Cycles between a read grant and its rvalid pulse, counted as tag stages.
  localparam int unsigned RD_LAT = 2;

  // Requester identity; also serves as the round-robin "last winner" pointer.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way pick: round-robin on last winner, or fixed priority
// to requester 0 when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  req_id_t    last,
  output logic [1:0] gnt,
  output req_id_t    winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt    = '0;
    winner = REQ0;
    if (elig[0]) begin
      gnt    = 2'b01;
      winner = REQ0;
    end else if (elig[1]) begin
      gnt    = 2'b10;
      winner = REQ1;
    end
  end
`else
  always_comb begin
    gnt    = '0;
    winner = REQ0;
    unique case (elig)
      2'b01: begin
        gnt    = 2'b01;
        winner = REQ0;
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = REQ1;
      end
      2'b11: begin
        if (last == REQ0) begin
          gnt    = 2'b10;
          winner = REQ1;
        end else begin
          gnt    = 2'b01;
          winner = REQ0;
        end
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory2 port between two requesters; read data is
// routed back by a tag pipeline. MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0_in,
  input  logic [ADDR_W-1:0] addr1_in,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        elig;
  logic [1:0]        pick;
  req_id_t           winner;
  req_id_t           last;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [RD_LAT-1:0] pipe_v;
  req_id_t           pipe_tag [RD_LAT];
  logic              ret0;
  logic              ret1;

  // A request seen during the requester's own grant cycle is the command
  // just accepted, so it must not be granted twice.
  assign elig    = {req1 & ~gnt1, req0 & ~gnt0};
  assign any_gnt = |pick;

  rr_pick u_pick (
    .elig   (elig),
    .last   (last),
    .gnt    (pick),
    .winner (winner)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last = REQ1;
`else
  always_ff @(posedge clk) begin
    if (!clr) begin
      last <= REQ1;
    end else if (any_gnt) begin
      last <= winner;
    end
  end
`endif

  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0_in;
    sel_wdata = wdata0;
    if (winner == REQ1) begin
      sel_we    = we1;
      sel_addr  = addr1_in;
      sel_wdata = wdata1;
    end
  end

  assign ret0 = pipe_v[RD_LAT-1] && (pipe_tag[RD_LAT-1] == REQ0);
  assign ret1 = pipe_v[RD_LAT-1] && (pipe_tag[RD_LAT-1] == REQ1);

  always_ff @(posedge clk) begin
    if (!clr) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pipe_v    <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_tag[i] <= REQ0;
      end
    end else begin
      gnt0   <= pick[0];
      gnt1   <= pick[1];
      mem_en <= any_gnt;
      if (any_gnt) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end else begin
        mem_we <= 1'b0;
      end
      pipe_v[0]   <= any_gnt & ~sel_we;
      pipe_tag[0] <= winner;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= ret0;
      rvalid1 <= ret1;
      if (ret0) begin
        rdata0 <= mem_rdata;
      end
      if (ret1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) !(gnt0 && gnt1));
  a_rvalid_onehot : assert property (@(posedge clk) !(rvalid0 && rvalid1));

endmodule
